// File: rtl/bit_reverse_accel_sched.sv
// Frame scheduler for the bit-reverse accelerator. It drives ap_ctrl_hs for a programmed number of
// frames and aborts the run on a per-frame timeout or on a sustained deadlock-monitor block.
module bit_reverse_accel_sched #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TO_W       = 20,
  parameter int unsigned BLK_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_clear,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  input  logic             block_in,
  output logic             busy,
  output logic             run_done,
  output logic [CNT_W-1:0] frames_done,
  output logic             err_timeout,
  output logic             err_deadlock
);

  localparam int unsigned      BLK_W   = $clog2(BLK_CYCLES + 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLK_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StWaitIdle,
    StStart,
    StWaitDone,
    StFinish,
    StError
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] frames_q;
  logic [CNT_W-1:0] frames_done_q;
  logic [TO_W-1:0]  timeout_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [BLK_W-1:0] blk_cnt_q;
  logic             ap_start_q;
  logic             busy_q;
  logic             run_done_q;
  logic             err_to_q;
  logic             err_dl_q;

  logic             in_frame;
  logic             frame_cmp;
  logic             to_hit;
  logic             blk_hit;
  logic [TO_W:0]    elapsed;
  logic [CNT_W-1:0] done_inc;
  logic [BLK_W-1:0] blk_inc;

  always_comb begin
    in_frame  = (state_q == StStart) || (state_q == StWaitDone);
    // A ready that arrives together with done closes the frame in one go.
    frame_cmp = ((state_q == StStart) && ap_ready && ap_done) ||
                ((state_q == StWaitDone) && ap_done);
    // elapsed counts the current cycle, so a frame may take at most cfg_timeout cycles.
    elapsed   = {1'b0, to_cnt_q} + 1'b1;
    to_hit    = in_frame && (timeout_q != '0) && (elapsed == {1'b0, timeout_q}) && !frame_cmp;
    blk_inc   = blk_cnt_q + 1'b1;
    blk_hit   = busy_q && block_in && (blk_inc == BLK_MAX) &&
                ((state_q == StWaitIdle) || in_frame);
    done_inc  = frames_done_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      frames_q      <= '0;
      frames_done_q <= '0;
      timeout_q     <= '0;
      to_cnt_q      <= '0;
      blk_cnt_q     <= '0;
      ap_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      err_to_q      <= 1'b0;
      err_dl_q      <= 1'b0;
    end else begin
      run_done_q <= 1'b0;

      if (busy_q && block_in) begin
        if (blk_cnt_q != BLK_MAX) blk_cnt_q <= blk_inc;
      end else begin
        blk_cnt_q <= '0;
      end

      if (in_frame && (to_cnt_q != '1)) to_cnt_q <= to_cnt_q + 1'b1;

      if (to_hit || blk_hit) begin
        err_to_q   <= err_to_q | to_hit;
        err_dl_q   <= err_dl_q | blk_hit;
        ap_start_q <= 1'b0;
        state_q    <= StError;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cfg_start) begin
              frames_done_q <= '0;
              frames_q      <= cfg_frames;
              timeout_q     <= cfg_timeout;
              if (cfg_frames != '0) begin
                busy_q  <= 1'b1;
                state_q <= StWaitIdle;
              end else begin
                state_q <= StFinish;
              end
            end
          end
          StWaitIdle: begin
            if (ap_idle) begin
              ap_start_q <= 1'b1;
              to_cnt_q   <= '0;
              state_q    <= StStart;
            end
          end
          StStart, StWaitDone: begin
            if (frame_cmp) begin
              frames_done_q <= done_inc;
              if (done_inc == frames_q) begin
                ap_start_q <= 1'b0;
                state_q    <= StFinish;
              end else begin
                ap_start_q <= 1'b1;
                to_cnt_q   <= '0;
                state_q    <= StStart;
              end
            end else if ((state_q == StStart) && ap_ready) begin
              ap_start_q <= 1'b0;
              state_q    <= StWaitDone;
            end
          end
          StFinish: begin
            run_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end
          StError: begin
            if (cfg_clear) begin
              err_to_q  <= 1'b0;
              err_dl_q  <= 1'b0;
              to_cnt_q  <= '0;
              blk_cnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Reset drops the start request without waiting for the edge.
  assign ap_start     = ap_start_q & ~reset;
  assign busy         = busy_q;
  assign run_done     = run_done_q;
  assign frames_done  = frames_done_q;
  assign err_timeout  = err_to_q;
  assign err_deadlock = err_dl_q;

endmodule

// File: tb/tb_bit_reverse_accel_sched.sv
// Scoreboard bench for bit_reverse_accel_sched: an ap_ctrl_hs accelerator model plus queues of
// expected frames_done values, checked when the DUT completes frames and runs.
module tb_bit_reverse_accel_sched;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned TO_W       = 20;
  localparam int unsigned BLK_CYCLES = 16;

  logic             clock;
  logic             reset;
  logic             cfg_start;
  logic             cfg_clear;
  logic [CNT_W-1:0] cfg_frames;
  logic [TO_W-1:0]  cfg_timeout;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic             block_in;
  logic             busy;
  logic             run_done;
  logic [CNT_W-1:0] frames_done;
  logic             err_timeout;
  logic             err_deadlock;

  bit_reverse_accel_sched #(
    .CNT_W      (CNT_W),
    .TO_W       (TO_W),
    .BLK_CYCLES (BLK_CYCLES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_start    (cfg_start),
    .cfg_clear    (cfg_clear),
    .cfg_frames   (cfg_frames),
    .cfg_timeout  (cfg_timeout),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .block_in     (block_in),
    .busy         (busy),
    .run_done     (run_done),
    .frames_done  (frames_done),
    .err_timeout  (err_timeout),
    .err_deadlock (err_deadlock)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int rd_cnt = 0;
  int start_cycles = 0;
  bit mon_en = 1'b1;
  int frame_q[$];
  int run_q[$];

  // Accelerator model knobs
  int ready_dly = 2;
  int done_dly = 10;
  bit same_cycle = 1'b0;
  bit never_done = 1'b0;
  bit idle_hold = 1'b0;
  bit m_flush = 1'b0;
  int phase = 0;
  int m_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Accelerator model: ready ready_dly cycles after start is seen, done done_dly cycles later.
  initial begin
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    ap_idle  = 1'b1;
    forever begin
      @(negedge clock);
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (reset || m_flush) begin
        phase   = 0;
        m_flush = 1'b0;
      end else begin
        if (phase == 0 && ap_start) begin
          phase = 1;
          m_cnt = 0;
        end
        if (phase == 1) begin
          if (m_cnt == ready_dly) begin
            ap_ready = 1'b1;
            if (same_cycle) begin
              ap_done = 1'b1;
              phase   = 0;
            end else begin
              phase = 2;
              m_cnt = 0;
            end
          end else begin
            m_cnt++;
          end
        end else if (phase == 2) begin
          m_cnt++;
          if (!never_done && m_cnt == done_dly) begin
            ap_done = 1'b1;
            phase   = 0;
          end
        end
      end
      ap_idle = (phase == 0) && !idle_hold;
    end
  end

  // Monitor: pops the scoreboard when a frame or a run completes.
  initial begin
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (!mon_en || reset) begin
        prev_done = 1'b0;
      end else begin
        if (ap_start && ap_ready) hs_cnt++;
        if (ap_start) start_cycles++;
        if (prev_done) begin
          check_val("frame_q_nonempty", 32'(frame_q.size() != 0), 32'd1);
          if (frame_q.size() != 0) check_val("frames_done_step", 32'(frames_done), frame_q.pop_front());
        end
        prev_done = ap_done && busy && !err_timeout && !err_deadlock;
        if (run_done) begin
          rd_cnt++;
          check_val("run_q_nonempty", 32'(run_q.size() != 0), 32'd1);
          if (run_q.size() != 0) check_val("frames_at_run_done", 32'(frames_done), run_q.pop_front());
          check_val("busy_at_run_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_ap_start"}, 32'(ap_start), 32'd0);
    check_val({pfx, "_busy"}, 32'(busy), 32'd0);
    check_val({pfx, "_run_done"}, 32'(run_done), 32'd0);
    check_val({pfx, "_frames_done"}, 32'(frames_done), 32'd0);
    check_val({pfx, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check_val({pfx, "_err_deadlock"}, 32'(err_deadlock), 32'd0);
  endtask

  // Drives a one-cycle cfg_start; returns at the negedge of the following cycle.
  task automatic start_run(input int frames, input int tmo, input bit expect_ok);
    cfg_frames  = CNT_W'(frames);
    cfg_timeout = TO_W'(tmo);
    cfg_start   = 1'b1;
    if (expect_ok) begin
      for (int i = 1; i <= frames; i++) frame_q.push_back(i);
      run_q.push_back(frames);
    end
    @(negedge clock);
    cfg_start = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int target;
    bit seen;
    target = rd_cnt + 1;
    seen   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (rd_cnt >= target) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("run_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic clear_err();
    cfg_clear = 1'b1;
    m_flush   = 1'b1;
    @(negedge clock);
    cfg_clear = 1'b0;
    check_val("clear_err_timeout", 32'(err_timeout), 32'd0);
    check_val("clear_err_deadlock", 32'(err_deadlock), 32'd0);
    check_val("clear_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int hs0;
    int rd0;
    int as0;
    bit found;
    reset       = 1'b1;
    cfg_start   = 1'b0;
    cfg_clear   = 1'b0;
    cfg_frames  = '0;
    cfg_timeout = '0;
    block_in    = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("por");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Normal 3-frame run
    hs0 = hs_cnt;
    rd0 = rd_cnt;
    start_run(3, 0, 1'b1);
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("no_start_in_wait_idle", 32'(ap_start), 32'd0);
    wait_run(200);
    repeat (3) @(negedge clock);
    check_val("normal_handshakes", 32'(hs_cnt - hs0), 32'd3);
    check_val("normal_run_done_pulses", 32'(rd_cnt - rd0), 32'd1);
    check_val("normal_busy_after", 32'(busy), 32'd0);
    check_val("normal_frames_done", 32'(frames_done), 32'd3);

    // Accelerator not idle: start is held back
    idle_hold = 1'b1;
    repeat (2) @(negedge clock);
    start_run(1, 0, 1'b1);
    repeat (5) @(negedge clock);
    check_val("start_held_by_idle", 32'(ap_start), 32'd0);
    check_val("busy_waiting_idle", 32'(busy), 32'd1);
    idle_hold = 1'b0;
    wait_run(100);
    repeat (2) @(negedge clock);

    // Zero frames: run_done two cycles after cfg_start, no ap_start
    as0 = start_cycles;
    start_run(0, 0, 1'b1);
    check_val("zero_run_done_early", 32'(run_done), 32'd0);
    @(negedge clock);
    check_val("zero_run_done_pulse", 32'(run_done), 32'd1);
    check_val("zero_frames_done", 32'(frames_done), 32'd0);
    repeat (3) @(negedge clock);
    check_val("zero_no_ap_start", 32'(start_cycles - as0), 32'd0);

    // Timeout of 50 cycles, accelerator never completes
    never_done = 1'b1;
    start_run(2, 50, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ap_start) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check_val("to_start_seen", 32'(found), 32'd1);
    repeat (49) @(negedge clock);
    check_val("to_not_yet", 32'(err_timeout), 32'd0);
    @(negedge clock);
    check_val("to_err_set", 32'(err_timeout), 32'd1);
    check_val("to_ap_start_low", 32'(ap_start), 32'd0);
    check_val("to_busy_high", 32'(busy), 32'd1);
    check_val("to_frames_frozen", 32'(frames_done), 32'd0);
    cfg_frames = 16'd5;
    cfg_start  = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
    @(negedge clock);
    check_val("start_in_error_ignored", 32'(err_timeout), 32'd1);
    check_val("busy_in_error", 32'(busy), 32'd1);
    clear_err();
    never_done = 1'b0;
    repeat (2) @(negedge clock);

    // Done lands on the last allowed cycle (index 12 of 13): no error
    start_run(1, 13, 1'b1);
    wait_run(100);
    check_val("to_boundary_no_err", 32'(err_timeout), 32'd0);
    repeat (2) @(negedge clock);

    // Deadlock: 15-cycle block burst is tolerated, 16th cycle of the next burst fires
    ready_dly = 1000000;
    start_run(1, 0, 1'b0);
    block_in = 1'b1;
    repeat (15) @(negedge clock);
    block_in = 1'b0;
    repeat (3) @(negedge clock);
    check_val("dl_short_burst_ok", 32'(err_deadlock), 32'd0);
    block_in = 1'b1;
    repeat (15) @(negedge clock);
    check_val("dl_before_16th", 32'(err_deadlock), 32'd0);
    @(negedge clock);
    check_val("dl_err_set", 32'(err_deadlock), 32'd1);
    check_val("dl_no_timeout", 32'(err_timeout), 32'd0);
    check_val("dl_ap_start_low", 32'(ap_start), 32'd0);
    block_in = 1'b0;
    clear_err();
    ready_dly = 2;
    repeat (2) @(negedge clock);

    // Ready and done in the same cycle count once per frame
    same_cycle = 1'b1;
    ready_dly  = 1;
    hs0 = hs_cnt;
    start_run(2, 0, 1'b1);
    wait_run(100);
    check_val("same_cycle_handshakes", 32'(hs_cnt - hs0), 32'd2);
    check_val("same_cycle_frames", 32'(frames_done), 32'd2);
    same_cycle = 1'b0;
    ready_dly  = 2;
    repeat (2) @(negedge clock);

    // cfg_start while busy is ignored
    rd0 = rd_cnt;
    start_run(2, 0, 1'b1);
    repeat (5) @(negedge clock);
    cfg_frames = 16'd7;
    cfg_start  = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
    wait_run(200);
    repeat (5) @(negedge clock);
    check_val("busy_start_frames", 32'(frames_done), 32'd2);
    check_val("busy_start_idle_after", 32'(busy), 32'd0);
    check_val("busy_start_one_run", 32'(rd_cnt - rd0), 32'd1);

    // Reset during frame 2 of 4, then a fresh 4-frame run
    start_run(4, 0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (frames_done == 16'd1 && ap_start) begin
        found = 1'b1;
        break;
      end
    end
    check_val("reach_frame2", 32'(found), 32'd1);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_val("ap_start_drops_on_reset", 32'(ap_start), 32'd0);
    @(negedge clock);
    check_reset_vals("midrun");
    frame_q.delete();
    run_q.delete();
    @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clock);
    hs0 = hs_cnt;
    start_run(4, 0, 1'b1);
    wait_run(300);
    check_val("rerun_handshakes", 32'(hs_cnt - hs0), 32'd4);
    check_val("rerun_frames", 32'(frames_done), 32'd4);

    repeat (3) @(negedge clock);
    check_val("frame_q_drained", 32'(frame_q.size()), 32'd0);
    check_val("run_q_drained", 32'(run_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
